// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell stepped LSB-first over WIDTH cycles.
// Optional subtract mode (a-b via ~b and carry-in of 1) enabled by SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic             s;
    logic             c;
    logic [WIDTH-1:0] acc_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1; cout then reads as "no borrow".
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    // Shared add cell and accumulator shift (loop form also covers WIDTH=1).
    always_comb begin
        s        = shift_a[0] ^ shift_b[0] ^ carry;
        c        = (shift_a[0] & shift_b[0]) | (carry & (shift_a[0] ^ shift_b[0]));
        acc_next = '0;
        acc_next[WIDTH-1] = s;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            acc_next[i] = acc[i+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b_load;
                        carry   <= carry_init;
                        cnt     <= '0;
                        acc     <= '0;
                        busy    <= 1'b1;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    carry   <= c;
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    acc     <= acc_next;
                    cnt     <= cnt + CntOne;
                    if (cnt == LastCnt) begin
                        sum   <= acc_next;
                        cout  <= c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
